// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit.
//   LU_OP_W  : opcode width
//   lu_op_e  : opcode encoding (NOT, OR, AND, NAND, NOR, XOR, XNOR, PASS)
package logic_unit_pkg;

  localparam int LU_OP_W = 3;

  typedef enum logic [LU_OP_W-1:0] {
    LU_NOT  = 3'd0,
    LU_OR   = 3'd1,
    LU_AND  = 3'd2,
    LU_NAND = 3'd3,
    LU_NOR  = 3'd4,
    LU_XOR  = 3'd5,
    LU_XNOR = 3'd6,
    LU_PASS = 3'd7
  } lu_op_e;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise logic core.
//   op   in  LU_OP_W  opcode (lu_op_e encoding)
//   a    in  WIDTH    operand A
//   b    in  WIDTH    operand B (unused for NOT/PASS)
//   y    out WIDTH    bitwise result
//   zero out 1        y == 0
//   par  out 1        XOR-reduction of y
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [LU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   y,
  output logic               zero,
  output logic               par
);

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    y = '0;
    case (lu_op_e'(op))
      LU_NOT:  y = ~a;
      LU_OR:   y = a | b;
      LU_AND:  y = a & b;
      LU_NAND: y = ~(a & b);
      LU_NOR:  y = ~(a | b);
      LU_XOR:  y = a ^ b;
      LU_XNOR: y = ~(a ^ b);
      LU_PASS: y = a;
    endcase
  end

  assign zero = (y == '0);
  assign par  = ^y;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit logic unit with optional accumulator and result flags.
// Two-stage valid/ready pipeline: full throughput, fixed 2-cycle latency,
// lossless under backpressure.
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_op, in_acc, in_a, in_b sampled on accept
//   acc_clr             clear accumulator (applied before a same-cycle acc op)
//   out_valid/out_ready output handshake; out_y, out_zero, out_par held while stalled
//   acc_q               current accumulator value (0 when ACC_EN=0)
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit ACC_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LU_OP_W-1:0] in_op,
  input  logic               in_acc,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_y,
  output logic               out_zero,
  output logic               out_par,
  output logic [WIDTH-1:0]   acc_q
);

  logic             s1_v, s2_v;
  logic [WIDTH-1:0] s1_y;
  logic             s1_zero, s1_par;
  logic             adv1, adv2, accept;
  logic [WIDTH-1:0] op_a, core_y;
  logic             core_zero, core_par;

  // s2 can take new data when empty or being drained; s1 when empty or
  // moving into s2. in_ready is therefore independent of in_valid.
  assign adv2     = ~s2_v | out_ready;
  assign adv1     = ~s1_v | adv2;
  assign in_ready = adv1;
  assign accept   = in_valid & in_ready;

  generate
    if (ACC_EN) begin : g_acc
      logic [WIDTH-1:0] acc_r;

      // A clear in the same cycle as an acc op zeroes operand A first.
      assign op_a  = in_acc ? (acc_clr ? '0 : acc_r) : in_a;
      assign acc_q = acc_r;

      always_ff @(posedge clk) begin
        if (rst) begin
          acc_r <= '0;
        end else if (accept && in_acc) begin
          acc_r <= core_y;
        end else if (acc_clr) begin
          acc_r <= '0;
        end
      end
    end else begin : g_no_acc
      assign op_a  = in_a;
      assign acc_q = '0;
    end
  endgenerate

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op   (in_op),
    .a    (op_a),
    .b    (in_b),
    .y    (core_y),
    .zero (core_zero),
    .par  (core_par)
  );

  assign out_valid = s2_v;

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, because out_y/flags must read 0 after reset.
    if (rst) begin
      s1_v     <= 1'b0;
      s1_y     <= '0;
      s1_zero  <= 1'b0;
      s1_par   <= 1'b0;
      s2_v     <= 1'b0;
      out_y    <= '0;
      out_zero <= 1'b0;
      out_par  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let s2 read the old s1 contents in the same edge.
      if (adv1) begin
        s1_v <= accept;
        if (accept) begin
          s1_y    <= core_y;
          s1_zero <= core_zero;
          s1_par  <= core_par;
        end
      end
      if (adv2) begin
        s2_v <= s1_v;
        if (s1_v) begin
          out_y    <= s1_y;
          out_zero <= s1_zero;
          out_par  <= s1_par;
        end
      end
    end
  end

endmodule
